pong_axil_regs: RTL and testbench



---
 rtl/pong_axil_regs_pkg.sv | 32 +++
 rtl/pong_axil_regs_if.sv | 52 +++++
 rtl/pong_axil_regs_wr_ctrl.sv | 115 +++++++++++
 rtl/pong_axil_regs.sv | 153 +++++++++++++++
 tb/tb_pong_axil_regs.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_axil_regs_pkg.sv
// pong_axil_pkg: shared constants and types for the pong AXI4-Lite register bank.
//   - Register byte offsets (REG_CTRL .. REG3) within the 16-byte window
//   - AXI response code RESP_OKAY (the only response this slave ever returns)
//   - Write/read channel state enums and the register index type
// Optional build macro used by the top: PONG_REGS_WR_PULSE_EN.
package pong_axil_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG1     = 4'h4;
  localparam logic [3:0] REG2     = 4'h8;
  localparam logic [3:0] REG3     = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/pong_axil_regs_if.sv
// pong_axil_regs_if: AXI4-Lite bus bundle between the AXI master and the pong
// register bank. Carries the five AXI4-Lite channels (AW, W, B, AR, R).
//   master modport: drives addresses, write data, valids and response readies
//   slave  modport: drives address/data readies and the B/R responses
interface pong_axil_regs_if
  import pong_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = DATA_W,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);

  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;

  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;

  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;

  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;

  logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/pong_axil_regs_wr_ctrl.sv
// pong_axil_wr_ctrl: AXI4-Lite write-channel controller.
// Accepts AW and W in either order (or together), latches whichever arrives
// first, and on the later handshake emits a one-cycle register write command.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   aw_idx_i/aw_valid_i    register index (addr[3:2]) and AW valid; aw_ready_o
//   w_data_i/w_strb_i      write data and byte strobes; w_valid_i; w_ready_o
//   b_ready_i/b_valid_o    write response handshake
//   wr_en_o, wr_idx_o, wr_data_o, wr_strb_o   write command to the register array
module pong_axil_wr_ctrl
  import pong_axil_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  reg_idx_t        aw_idx_i,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_strb_i,
  input  logic            w_valid_i,
  output logic            w_ready_o,
  input  logic            b_ready_i,
  output logic            b_valid_o,
  output logic            wr_en_o,
  output reg_idx_t        wr_idx_o,
  output logic [DW-1:0]   wr_data_o,
  output logic [DW/8-1:0] wr_strb_o
);

  wr_state_e       state_q, state_d;
  reg_idx_t        idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW/8-1:0] strb_q, strb_d;
  // Readies stay low until the first clock edge after reset release.
  logic            live_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= W_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      live_q  <= 1'b1;
    end
  end

  // The write command is issued combinationally on the later handshake so the
  // register array and BVALID both update on the same edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    strb_d     = strb_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    wr_en_o    = 1'b0;
    wr_idx_o   = idx_q;
    wr_data_o  = data_q;
    wr_strb_o  = strb_q;
    case (state_q)
      W_IDLE: begin
        aw_ready_o = live_q;
        w_ready_o  = live_q;
        if (live_q) begin
          if (aw_valid_i && w_valid_i) begin
            wr_en_o   = 1'b1;
            wr_idx_o  = aw_idx_i;
            wr_data_o = w_data_i;
            wr_strb_o = w_strb_i;
            state_d   = W_RESP;
          end else if (aw_valid_i) begin
            idx_d   = aw_idx_i;
            state_d = W_HAVE_AW;
          end else if (w_valid_i) begin
            data_d  = w_data_i;
            strb_d  = w_strb_i;
            state_d = W_HAVE_W;
          end
        end
      end
      W_HAVE_AW: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          wr_en_o   = 1'b1;
          wr_data_o = w_data_i;
          wr_strb_o = w_strb_i;
          state_d   = W_RESP;
        end
      end
      W_HAVE_W: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          wr_en_o  = 1'b1;
          wr_idx_o = aw_idx_i;
          state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign b_valid_o = (state_q == W_RESP);

endmodule

// File: rtl/pong_axil_regs.sv
// pong_axil_regs: AXI4-Lite slave with four 32-bit R/W registers (0x0..0xC)
// presented in parallel to the pong game logic.
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   s_axi                  AXI4-Lite slave bus (pong_axil_regs_if.slave)
//   reg0_o .. reg3_o       current register contents
//   reg_wr_pulse_o         one-cycle per-register write strobe, present only
//                          when PONG_REGS_WR_PULSE_EN is defined
module pong_axil_regs
  import pong_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  pong_axil_regs_if.slave               s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o
`ifdef PONG_REGS_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]           reg_wr_pulse_o
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic          wr_en;
  reg_idx_t      wr_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  reg_idx_t      aw_idx, ar_idx;

  // Byte-address bits [1:0] and the PROT fields carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT,
                         s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  assign aw_idx = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1 -: 2];
  assign ar_idx = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1 -: 2];

  pong_axil_wr_ctrl #(.DW(DW)) u_wr_ctrl (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .aw_idx_i   (aw_idx),
    .aw_valid_i (s_axi.AWVALID),
    .aw_ready_o (s_axi.AWREADY),
    .w_data_i   (s_axi.WDATA),
    .w_strb_i   (s_axi.WSTRB),
    .w_valid_i  (s_axi.WVALID),
    .w_ready_o  (s_axi.WREADY),
    .b_ready_i  (s_axi.BREADY),
    .b_valid_o  (s_axi.BVALID),
    .wr_en_o    (wr_en),
    .wr_idx_o   (wr_idx),
    .wr_data_o  (wr_data),
    .wr_strb_o  (wr_strb)
  );

  assign s_axi.BRESP = RESP_OKAY;

  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];

  // Byte-lane merge of the write command into the addressed register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (wr_en && (wr_idx == reg_idx_t'(r))) begin
        for (int b = 0; b < SW; b++) begin
          if (wr_strb[b]) regs_d[r][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];

  // Read channel: RDATA is captured from regs_q, so a write committing on the
  // same edge is not yet visible and the old value is returned.
  rd_state_e     rd_state_q, rd_state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_live_q;
  logic          arready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rd_live_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rd_live_q  <= 1'b1;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    arready    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        arready = rd_live_q;
        if (rd_live_q && s_axi.ARVALID) begin
          rdata_d    = regs_q[ar_idx];
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi.RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = (rd_state_q == R_RESP);
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = RESP_OKAY;

`ifdef PONG_REGS_WR_PULSE_EN
  // Pulse is registered so it lines up with the cycle the new value appears.
  logic [NUM_REGS-1:0] wr_pulse_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_pulse_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        wr_pulse_q[r] <= wr_en && (wr_idx == reg_idx_t'(r));
      end
    end
  end

  assign reg_wr_pulse_o = wr_pulse_q;
`endif

endmodule

// File: tb/tb_pong_axil_regs.sv
// tb_pong_axil_regs: directed self-checking bench for pong_axil_regs.
// Exercises reset, sequential write/read-back, W-before-AW ordering, byte
// strobes, B back-pressure, same-edge read/write, and mid-transaction reset.
// Optional checks for PONG_REGS_WR_PULSE_EN when that macro is defined.
module tb_pong_axil_regs;
  import pong_axil_pkg::*;

  logic ACLK;
  logic ARESETN;
  logic [31:0] reg0, reg1, reg2, reg3;
`ifdef PONG_REGS_WR_PULSE_EN
  logic [3:0] pulse;
`endif

  int errors = 0;
  int checks = 0;

  pong_axil_regs_if bus ();

  pong_axil_regs dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axi   (bus),
    .reg0_o  (reg0),
    .reg1_o  (reg1),
    .reg2_o  (reg2),
    .reg3_o  (reg3)
`ifdef PONG_REGS_WR_PULSE_EN
    ,
    .reg_wr_pulse_o (pulse)
`endif
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Drives one full write (AW+W together, BREADY high); returns BRESP.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_hs, w_hs;
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1;
    resp = 2'bxx;
    for (int i = 0; i < 20 && (bus.AWVALID || bus.WVALID); i++) begin
      @(negedge ACLK);
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) bus.AWVALID = 1'b0;
      if (w_hs)  bus.WVALID  = 1'b0;
    end
    checks++;
    if (bus.AWVALID || bus.WVALID) begin
      errors++;
      $display("[TB] FAIL write_accept addr=%h: handshake timeout", addr);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.BVALID) begin
        resp = bus.BRESP;
        break;
      end
    end
    @(posedge ACLK); #1;
  endtask

  // Drives one full read (RREADY high); returns RDATA/RRESP.
  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic ar_hs;
    logic got;
    bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    data = 'x; resp = 'x; got = 1'b0;
    for (int i = 0; i < 20 && bus.ARVALID; i++) begin
      @(negedge ACLK);
      ar_hs = bus.ARVALID && bus.ARREADY;
      @(posedge ACLK); #1;
      if (ar_hs) bus.ARVALID = 1'b0;
    end
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      if (bus.RVALID) begin
        data = bus.RDATA; resp = bus.RRESP; got = 1'b1;
      end
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b1;
    #2 ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=00000",
               {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
    end
    checks++;
    if ({reg0, reg1, reg2, reg3, bus.RDATA} !== 160'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got=%h %h %h %h rdata=%h exp=0",
               reg0, reg1, reg2, reg3, bus.RDATA);
    end
    checks++;
    if ({bus.BRESP, bus.RRESP} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_resp got=%b exp=0000", {bus.BRESP, bus.RRESP});
    end
    #1 ARESETN = 1'b1;
    #2;
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL ready_before_edge got=%b exp=000",
               {bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
    @(posedge ACLK); #1;
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL ready_after_edge got=%b exp=111",
               {bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
  endtask

  task automatic test_write_readback();
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [3:0]  addrs [4];
    addrs[0] = REG_CTRL; addrs[1] = REG1; addrs[2] = REG2; addrs[3] = REG3;
    for (int i = 0; i < 4; i++) begin
      axi_write(addrs[i], 32'(i + 1), 4'hF, resp);
      checks++;
      if (resp !== RESP_OKAY) begin
        errors++;
        $display("[TB] FAIL bresp_%0d got=%b exp=00", i, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], rd, resp);
      checks++;
      if (rd !== 32'(i + 1) || resp !== RESP_OKAY) begin
        errors++;
        $display("[TB] FAIL readback_%0d got=%h/%b exp=%h/00", i, rd, resp, i + 1);
      end
    end
    checks++;
    if ({reg0, reg1, reg2, reg3} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      errors++;
      $display("[TB] FAIL reg_outputs got=%h %h %h %h exp=1 2 3 4", reg0, reg1, reg2, reg3);
    end
  endtask

  task automatic test_w_before_aw();
    bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.AWVALID = 1'b0; bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.WREADY !== 1'b0 || bus.AWREADY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL w_first_ready_%0d got=w%b aw%b exp=w0 aw1", i, bus.WREADY, bus.AWREADY);
      end
      if (i < 2) begin
        @(posedge ACLK); #1;
      end
    end
    checks++;
    if (reg2 !== 32'd3) begin
      errors++;
      $display("[TB] FAIL w_first_early got=%h exp=00000003", reg2);
    end
    bus.AWADDR = 4'h8; bus.AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    checks++;
    if (reg2 !== 32'hDEADBEEF || bus.BVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL w_first_commit got=%h bvalid=%b exp=deadbeef/1", reg2, bus.BVALID);
    end
    @(posedge ACLK); #1;
    checks++;
    if (bus.BVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w_first_bdone got=%b exp=0", bus.BVALID);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0] resp;
    axi_write(REG1, 32'h0, 4'hF, resp);
    axi_write(REG1, 32'hAABBCCDD, 4'b0101, resp);
    checks++;
    if (reg1 !== 32'h00BB00DD) begin
      errors++;
      $display("[TB] FAIL wstrb_0101 got=%h exp=00bb00dd", reg1);
    end
    axi_write(REG1, 32'h12345678, 4'b0000, resp);
    checks++;
    if (reg1 !== 32'h00BB00DD || resp !== RESP_OKAY) begin
      errors++;
      $display("[TB] FAIL wstrb_zero got=%h/%b exp=00bb00dd/00", reg1, resp);
    end
  endtask

  task automatic test_back_to_back();
    bus.AWADDR = REG3; bus.WDATA = 32'h11; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL bstall_%0d got=%b exp=100", i, {bus.BVALID, bus.AWREADY, bus.WREADY});
      end
      if (i == 1) begin
        bus.WDATA = 32'h22; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
      end
      @(posedge ACLK); #1;
    end
    checks++;
    if (reg3 !== 32'h11) begin
      errors++;
      $display("[TB] FAIL bstall_hold got=%h exp=00000011", reg3);
    end
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || reg3 !== 32'h11) begin
      errors++;
      $display("[TB] FAIL bstall_release got=b%b aw%b r%h exp=b0 aw1 r11", bus.BVALID, bus.AWREADY, reg3);
    end
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    checks++;
    if (reg3 !== 32'h22 || bus.BVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL second_write got=%h bvalid=%b exp=22/1", reg3, bus.BVALID);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_same_edge();
    logic [31:0] rd;
    logic [1:0]  resp;
    axi_write(REG_CTRL, 32'h5, 4'hF, resp);
    bus.AWADDR = REG_CTRL; bus.WDATA = 32'h9; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    bus.ARADDR = REG_CTRL; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h5 || reg0 !== 32'h9) begin
      errors++;
      $display("[TB] FAIL same_edge got=rv%b rd%h r0 %h exp=rv1 rd5 r0 9", bus.RVALID, bus.RDATA, reg0);
    end
    @(posedge ACLK); #1;
    axi_read(REG_CTRL, rd, resp);
    checks++;
    if (rd !== 32'h9) begin
      errors++;
      $display("[TB] FAIL same_edge_after got=%h exp=00000009", rd);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] resp;
    axi_write(REG2, 32'h3, 4'hF, resp);
    bus.ARADDR = REG2; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h3) begin
      errors++;
      $display("[TB] FAIL rpending got=%b/%h exp=1/3", bus.RVALID, bus.RDATA);
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({bus.RVALID, bus.ARREADY, bus.AWREADY} !== 3'b000 ||
        {reg0, reg1, reg2, reg3, bus.RDATA} !== 160'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got=%b regs=%h %h %h %h rd=%h exp=000/0",
               {bus.RVALID, bus.ARREADY, bus.AWREADY}, reg0, reg1, reg2, reg3, bus.RDATA);
    end
    @(negedge ACLK); #1;
    ARESETN = 1'b1;
    #1;
    checks++;
    if (bus.ARREADY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arready_pre_edge got=%b exp=0", bus.ARREADY);
    end
    @(posedge ACLK); #1;
    checks++;
    if (bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0 || bus.BVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset got=ar%b rv%b bv%b exp=ar1 rv0 bv0", bus.ARREADY, bus.RVALID, bus.BVALID);
    end
  endtask

`ifdef PONG_REGS_WR_PULSE_EN
  task automatic test_wr_pulse();
    bus.AWADDR = REG1; bus.WDATA = 32'h77; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    checks++;
    if (pulse !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL pulse_reg1 got=%b exp=0010", pulse);
    end
    @(posedge ACLK); #1;
    checks++;
    if (pulse !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL pulse_clear got=%b exp=0000", pulse);
    end
    bus.AWADDR = REG3; bus.WSTRB = 4'h0;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    checks++;
    if (pulse !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL pulse_zero_strb got=%b exp=1000", pulse);
    end
    @(posedge ACLK); #1;
  endtask
`endif

  initial begin
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    test_reset();
    test_write_readback();
    test_w_before_aw();
    test_wstrb();
    test_back_to_back();
    test_same_edge();
`ifdef PONG_REGS_WR_PULSE_EN
    test_wr_pulse();
`endif
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
